// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: walks LOGN stages of N/2 butterflies, issuing
// read addresses and twiddle index each cycle and returning write-back addresses PIPE cycles later.
module fft_ctrl #(
    parameter int unsigned LOGN = 10,
    parameter int unsigned PIPE = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(LOGN)-1:0]   stage,
    output logic                      rd_en,
    output logic [LOGN-1:0]           addr_a,
    output logic [LOGN-1:0]           addr_b,
    output logic [LOGN-2:0]           tw_idx,
    output logic                      wr_en,
    output logic [LOGN-1:0]           wr_addr_a,
    output logic [LOGN-1:0]           wr_addr_b
);

    localparam int unsigned SW = $clog2(LOGN);
    localparam int unsigned KW = LOGN - 1;
    localparam int unsigned EW = 2 * LOGN + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic [2:0]      dcnt;
    logic [EW-1:0]   pipe [PIPE];

    always_comb begin
        logic [LOGN-1:0] kx;
        logic [LOGN-1:0] half;
        logic [LOGN-1:0] j;
        logic [LOGN-1:0] g;
        logic [LOGN-1:0] a;
        addr_a = '0;
        addr_b = '0;
        tw_idx = '0;
        kx     = LOGN'(k);
        half   = LOGN'(1) << stage;
        j      = kx & (half - 1'b1);
        g      = kx >> stage;
        a      = (g << (int'(stage) + 1)) | j;
        if (state == RUN) begin
            addr_a = a;
            addr_b = a + half;
            tw_idx = KW'(j << (LOGN - 1 - int'(stage)));
        end
    end

    assign wr_en     = pipe[PIPE-1][EW-1];
    assign wr_addr_a = pipe[PIPE-1][2*LOGN-1:LOGN];
    assign wr_addr_b = pipe[PIPE-1][LOGN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            stage <= '0;
            k     <= '0;
            dcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            rd_en <= 1'b0;
            for (int unsigned i = 0; i < PIPE; i++) pipe[i] <= '0;
        end else if (abort) begin
            state <= IDLE;
            stage <= '0;
            k     <= '0;
            dcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            rd_en <= 1'b0;
            for (int unsigned i = 0; i < PIPE; i++) pipe[i] <= '0;
        end else begin
            done    <= 1'b0;
            pipe[0] <= {rd_en, addr_a, addr_b};
            for (int unsigned i = 1; i < PIPE; i++) pipe[i] <= pipe[i-1];
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        stage <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        rd_en <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (k == '1) begin
                        state <= DRAIN;
                        k     <= '0;
                        dcnt  <= 3'(PIPE - 1);
                        rd_en <= 1'b0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    // Next stage starts only after the last write of this one has landed.
                    if (dcnt == '0) begin
                        if (stage != SW'(LOGN - 1)) begin
                            stage <= stage + 1'b1;
                            state <= RUN;
                            rd_en <= 1'b1;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed self-checking bench for fft_ctrl: LOGN=3 instances for sequencing and
// alignment, LOGN=10 instance driving a RAM plus butterfly model end to end.
module tb_fft_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // LOGN=3, PIPE=2
    logic       a_start, a_abort, a_busy, a_done, a_rd_en, a_wr_en;
    logic [1:0] a_stage, a_tw;
    logic [2:0] a_addr_a, a_addr_b, a_wr_a, a_wr_b;
    // LOGN=3, PIPE=1
    logic       p1_start, p1_abort, p1_busy, p1_done, p1_rd_en, p1_wr_en;
    logic [1:0] p1_stage, p1_tw;
    logic [2:0] p1_addr_a, p1_addr_b, p1_wr_a, p1_wr_b;
    // LOGN=3, PIPE=4
    logic       p4_start, p4_abort, p4_busy, p4_done, p4_rd_en, p4_wr_en;
    logic [1:0] p4_stage, p4_tw;
    logic [2:0] p4_addr_a, p4_addr_b, p4_wr_a, p4_wr_b;
    // LOGN=10, PIPE=2
    logic       b_start, b_abort, b_busy, b_done, b_rd_en, b_wr_en;
    logic [3:0] b_stage;
    logic [8:0] b_tw;
    logic [9:0] b_addr_a, b_addr_b, b_wr_a, b_wr_b;

    fft_ctrl #(.LOGN(3), .PIPE(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
        .busy(a_busy), .done(a_done), .stage(a_stage), .rd_en(a_rd_en),
        .addr_a(a_addr_a), .addr_b(a_addr_b), .tw_idx(a_tw),
        .wr_en(a_wr_en), .wr_addr_a(a_wr_a), .wr_addr_b(a_wr_b));

    fft_ctrl #(.LOGN(3), .PIPE(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .start(p1_start), .abort(p1_abort),
        .busy(p1_busy), .done(p1_done), .stage(p1_stage), .rd_en(p1_rd_en),
        .addr_a(p1_addr_a), .addr_b(p1_addr_b), .tw_idx(p1_tw),
        .wr_en(p1_wr_en), .wr_addr_a(p1_wr_a), .wr_addr_b(p1_wr_b));

    fft_ctrl #(.LOGN(3), .PIPE(4)) u_p4 (
        .clk(clk), .rst_n(rst_n), .start(p4_start), .abort(p4_abort),
        .busy(p4_busy), .done(p4_done), .stage(p4_stage), .rd_en(p4_rd_en),
        .addr_a(p4_addr_a), .addr_b(p4_addr_b), .tw_idx(p4_tw),
        .wr_en(p4_wr_en), .wr_addr_a(p4_wr_a), .wr_addr_b(p4_wr_b));

    fft_ctrl #(.LOGN(10), .PIPE(2)) u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
        .busy(b_busy), .done(b_done), .stage(b_stage), .rd_en(b_rd_en),
        .addr_a(b_addr_a), .addr_b(b_addr_b), .tw_idx(b_tw),
        .wr_en(b_wr_en), .wr_addr_a(b_wr_a), .wr_addr_b(b_wr_b));

    // Hand-derived LOGN=3 butterfly schedule, one entry per RUN cycle.
    int exp_a [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int exp_b [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int exp_t [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    typedef struct {
        real ar, ai, br, bi;
        int  tw, ia, ib;
    } bfly_t;

    real   ram_re [1024];
    real   ram_im [1024];
    bfly_t inflight [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int  n;
        bit  early_done;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({a_busy, a_done, a_rd_en, a_wr_en, a_stage, a_tw, a_addr_a, a_addr_b, a_wr_a, a_wr_b} !== '0) begin
            errors++;
            $display("FAIL reset_a: got %h expected 0",
                {a_busy, a_done, a_rd_en, a_wr_en, a_stage, a_tw, a_addr_a, a_addr_b, a_wr_a, a_wr_b});
        end
        checks++;
        if ({p1_busy, p1_done, p1_rd_en, p1_wr_en, p1_stage, p1_tw, p1_addr_a, p1_addr_b, p1_wr_a, p1_wr_b,
             p4_busy, p4_done, p4_rd_en, p4_wr_en, p4_stage, p4_tw, p4_addr_a, p4_addr_b, p4_wr_a, p4_wr_b} !== '0) begin
            errors++;
            $display("FAIL reset_p1p4: outputs not all zero");
        end
        checks++;
        if ({b_busy, b_done, b_rd_en, b_wr_en, b_stage, b_tw, b_addr_a, b_addr_b, b_wr_a, b_wr_b} !== '0) begin
            errors++;
            $display("FAIL reset_big: outputs not all zero");
        end
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        checks++;
        if ({a_rd_en, a_busy} !== 2'b11) begin
            errors++;
            $display("FAIL first_read: rd_en,busy got %b expected 11", {a_rd_en, a_busy});
        end
        n = 0;
        early_done = 1'b0;
        while (a_busy === 1'b1 && n < 100) begin
            if (a_done !== 1'b0) early_done = 1'b1;
            n++;
            tick();
        end
        checks++;
        if (n != 18) begin
            errors++;
            $display("FAIL busy_length: got %0d expected 18", n);
        end
        checks++;
        if (early_done) begin
            errors++;
            $display("FAIL done_while_busy: got 1 expected 0");
        end
        checks++;
        if (a_done !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: got %b expected 1", a_done);
        end
        tick();
        checks++;
        if ({a_done, a_busy} !== 2'b00) begin
            errors++;
            $display("FAIL done_width: done,busy got %b expected 00", {a_done, a_busy});
        end
    endtask

    task automatic test_addr_seq();
        int n;
        int idx;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n = 0;
        idx = 0;
        while (a_done !== 1'b1 && n < 100) begin
            if (a_rd_en === 1'b1) begin
                if (idx < 12) begin
                    checks++;
                    if ({a_stage, a_addr_a, a_addr_b, a_tw} !==
                        {2'(idx / 4), 3'(exp_a[idx]), 3'(exp_b[idx]), 2'(exp_t[idx])}) begin
                        errors++;
                        $display("FAIL addr_seq[%0d]: stage,a,b,tw got %0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d",
                            idx, a_stage, a_addr_a, a_addr_b, a_tw, idx / 4, exp_a[idx], exp_b[idx], exp_t[idx]);
                    end
                end
                idx++;
            end else begin
                checks++;
                if ({a_addr_a, a_addr_b, a_tw} !== '0) begin
                    errors++;
                    $display("FAIL addr_idle_zero: got %h expected 0", {a_addr_a, a_addr_b, a_tw});
                end
            end
            n++;
            tick();
        end
        checks++;
        if (idx != 12 || a_done !== 1'b1) begin
            errors++;
            $display("FAIL read_count: got %0d reads done=%b expected 12 reads done=1", idx, a_done);
        end
        tick();
    endtask

    task automatic test_write_align();
        logic [6:0] h1 [64];
        logic [6:0] h4 [64];
        logic [6:0] e;
        bit seen1, seen4, late1, late4;
        seen1 = 1'b0; seen4 = 1'b0; late1 = 1'b0; late4 = 1'b0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            h1[cyc] = {p1_rd_en, p1_addr_a, p1_addr_b};
            h4[cyc] = {p4_rd_en, p4_addr_a, p4_addr_b};
            e = (cyc >= 1) ? h1[cyc-1] : 7'd0;
            checks++;
            if (e[6] ? ({p1_wr_en, p1_wr_a, p1_wr_b} !== e) : (p1_wr_en !== 1'b0)) begin
                errors++;
                $display("FAIL wr_align_p1 cyc %0d: got %b expected %b", cyc, {p1_wr_en, p1_wr_a, p1_wr_b}, e);
            end
            e = (cyc >= 4) ? h4[cyc-4] : 7'd0;
            checks++;
            if (e[6] ? ({p4_wr_en, p4_wr_a, p4_wr_b} !== e) : (p4_wr_en !== 1'b0)) begin
                errors++;
                $display("FAIL wr_align_p4 cyc %0d: got %b expected %b", cyc, {p4_wr_en, p4_wr_a, p4_wr_b}, e);
            end
            if ((seen1 || p1_done === 1'b1) && p1_wr_en !== 1'b0) late1 = 1'b1;
            if ((seen4 || p4_done === 1'b1) && p4_wr_en !== 1'b0) late4 = 1'b1;
            if (p1_done === 1'b1) seen1 = 1'b1;
            if (p4_done === 1'b1) seen4 = 1'b1;
            p1_start = (cyc == 0);
            p4_start = (cyc == 0);
            tick();
        end
        p1_start = 1'b0;
        p4_start = 1'b0;
        checks++;
        if (!(seen1 && seen4)) begin
            errors++;
            $display("FAIL wr_done_seen: got p1=%b p4=%b expected 1,1", seen1, seen4);
        end
        checks++;
        if (late1 || late4) begin
            errors++;
            $display("FAIL wr_after_done: got p1=%b p4=%b expected 0,0", late1, late4);
        end
    endtask

    task automatic test_start_busy();
        int n;
        int idx;
        bit bad;
        a_start = 1'b1;
        tick();
        n = 0;
        idx = 0;
        bad = 1'b0;
        while (a_busy === 1'b1 && n < 100) begin
            a_start = 1'b0;
            if (a_rd_en === 1'b1) begin
                if (idx < 12 && {a_addr_a, a_addr_b, a_tw} !== {3'(exp_a[idx]), 3'(exp_b[idx]), 2'(exp_t[idx])})
                    bad = 1'b1;
                if (idx == 5) a_start = 1'b1;
                idx++;
            end
            n++;
            tick();
        end
        a_start = 1'b0;
        checks++;
        if (bad || idx != 12) begin
            errors++;
            $display("FAIL start_busy_seq: got bad=%b reads=%0d expected bad=0 reads=12", bad, idx);
        end
        checks++;
        if (n != 18 || a_done !== 1'b1) begin
            errors++;
            $display("FAIL start_busy_len: got busy=%0d done=%b expected 18,1", n, a_done);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        a_start = 1'b1;
        tick();
        n = 0;
        while (a_done !== 1'b1 && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (a_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: got %b expected 1", a_done);
        end
        tick();
        checks++;
        if ({a_busy, a_rd_en, a_stage, a_addr_a, a_addr_b, a_tw} !== {1'b1, 1'b1, 2'd0, 3'd0, 3'd1, 2'd0}) begin
            errors++;
            $display("FAIL b2b_restart: busy,rd,stage,a,b,tw got %b,%b,%0d,%0d,%0d,%0d expected 1,1,0,0,1,0",
                a_busy, a_rd_en, a_stage, a_addr_a, a_addr_b, a_tw);
        end
        a_start = 1'b0;
        n = 0;
        while (a_busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (n != 18 || a_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_len: got busy=%0d done=%b expected 18,1", n, a_done);
        end
        tick();
    endtask

    task automatic test_abort();
        int n;
        bit bad;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n = 0;
        while (!(a_rd_en === 1'b1 && a_stage === 2'd1 && a_addr_a === 3'd4) && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL abort_reach: got timeout expected stage1 k=2");
        end
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        checks++;
        if ({a_busy, a_rd_en, a_wr_en, a_done, a_stage} !== '0) begin
            errors++;
            $display("FAIL abort_idle: busy,rd,wr,done,stage got %b expected 0", {a_busy, a_rd_en, a_wr_en, a_done, a_stage});
        end
        bad = 1'b0;
        repeat (10) begin
            if (a_done !== 1'b0 || a_wr_en !== 1'b0 || a_busy !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL abort_quiet: got activity expected none");
        end
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        checks++;
        if ({a_rd_en, a_stage, a_addr_a, a_addr_b, a_tw} !== {1'b1, 2'd0, 3'd0, 3'd1, 2'd0}) begin
            errors++;
            $display("FAIL abort_restart: rd,stage,a,b,tw got %b,%0d,%0d,%0d,%0d expected 1,0,0,1,0",
                a_rd_en, a_stage, a_addr_a, a_addr_b, a_tw);
        end
        n = 0;
        while (a_busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (n != 18 || a_done !== 1'b1) begin
            errors++;
            $display("FAIL abort_rerun_len: got busy=%0d done=%b expected 18,1", n, a_done);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int n;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n = 0;
        while (!(a_busy === 1'b1 && a_rd_en === 1'b0) && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (a_wr_en !== 1'b1 || n >= 100) begin
            errors++;
            $display("FAIL drain_pending_write: got wr_en=%b expected 1", a_wr_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_busy, a_done, a_rd_en, a_wr_en, a_stage, a_tw, a_addr_a, a_addr_b, a_wr_a, a_wr_b} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0",
                {a_busy, a_done, a_rd_en, a_wr_en, a_stage, a_tw, a_addr_a, a_addr_b, a_wr_a, a_wr_b});
        end
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({a_busy, a_done, a_rd_en, a_wr_en} !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected 0000", {a_busy, a_done, a_rd_en, a_wr_en});
        end
    endtask

    task automatic test_end_to_end();
        int    n;
        int    bad_bins;
        int    addr_err;
        int    underflow;
        bfly_t t;
        real   th, wr, wi, tr, ti;
        for (int i = 0; i < 1024; i++) begin
            ram_re[i] = 0.0;
            ram_im[i] = 0.0;
        end
        ram_re[0] = 1.0;
        inflight.delete();
        addr_err = 0;
        underflow = 0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n = 0;
        while (b_done !== 1'b1 && n < 8000) begin
            if (b_wr_en === 1'b1) begin
                if (inflight.size() == 0) begin
                    underflow++;
                end else begin
                    t = inflight.pop_front();
                    if (t.ia != int'(b_wr_a) || t.ib != int'(b_wr_b)) addr_err++;
                    th = 2.0 * 3.14159265358979 * real'(t.tw) / 1024.0;
                    wr = $cos(th);
                    wi = -$sin(th);
                    tr = t.br * wr - t.bi * wi;
                    ti = t.br * wi + t.bi * wr;
                    ram_re[b_wr_a] = t.ar + tr;
                    ram_im[b_wr_a] = t.ai + ti;
                    ram_re[b_wr_b] = t.ar - tr;
                    ram_im[b_wr_b] = t.ai - ti;
                end
            end
            if (b_rd_en === 1'b1) begin
                t.ar = ram_re[b_addr_a];
                t.ai = ram_im[b_addr_a];
                t.br = ram_re[b_addr_b];
                t.bi = ram_im[b_addr_b];
                t.tw = int'(b_tw);
                t.ia = int'(b_addr_a);
                t.ib = int'(b_addr_b);
                inflight.push_back(t);
            end
            n++;
            tick();
        end
        checks++;
        if (b_done !== 1'b1) begin
            errors++;
            $display("FAIL e2e_done: got timeout after %0d cycles expected done", n);
        end
        checks++;
        if (inflight.size() != 0 || underflow != 0 || addr_err != 0) begin
            errors++;
            $display("FAIL e2e_writes: got pending=%0d underflow=%0d addr_err=%0d expected 0,0,0",
                inflight.size(), underflow, addr_err);
        end
        bad_bins = 0;
        for (int i = 0; i < 1024; i++) begin
            if (ram_re[i] - 1.0 > 1e-6 || ram_re[i] - 1.0 < -1e-6 || ram_im[i] > 1e-6 || ram_im[i] < -1e-6)
                bad_bins++;
        end
        checks++;
        if (bad_bins != 0) begin
            errors++;
            $display("FAIL e2e_bins: got %0d bins not 1+0j expected 0 (bin0 = %f %f)", bad_bins, ram_re[0], ram_im[0]);
        end
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        a_start  = 1'b0; a_abort  = 1'b0;
        p1_start = 1'b0; p1_abort = 1'b0;
        p4_start = 1'b0; p4_abort = 1'b0;
        b_start  = 1'b0; b_abort  = 1'b0;
        test_reset();
        test_addr_seq();
        test_write_align();
        test_start_busy();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_end_to_end();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_ctrl.md
# fft_ctrl

In-place radix-2 decimation-in-time FFT sequencer for the FFT datapath. It walks all LOGN stages of an N = 2^LOGN point transform. Each cycle it issues one butterfly's read addresses and twiddle index to the sample RAM and twiddle ROM. It then returns write-back addresses to the same RAM after the butterfly pipeline latency. Samples are bit-reversed at load time, before start, so the controller only schedules stages.

## Interface

- LOGN, 10, log2 of transform size N; legal range 2..12
- PIPE, 2, cycles from rd_en to matching wr_en (RAM read latency plus output register); legal range 1..4
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin transform; sampled only in IDLE or DONE
- abort  in  1  synchronous cancel; highest priority after reset
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at end of transform
- stage  out  log2(LOGN) rounded up  current stage s
- rd_en  out  1  read butterfly inputs at addr_a/addr_b
- addr_a, addr_b  out  LOGN  butterfly input addresses
- tw_idx  out  LOGN-1  twiddle exponent k for W_N^k
- wr_en  out  1  write butterfly outputs
- wr_addr_a, wr_addr_b  out  LOGN  write-back addresses (c to wr_addr_a, d to wr_addr_b)

## Operation

- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE -> RUN on start. On entry, set s=0 and butterfly counter k=0.
- RUN
  - rd_en=1 every cycle; k increments.
  - After the cycle with k=N/2-1: go to DRAIN and load the drain counter with PIPE-1.
- DRAIN
  - rd_en=0; counter decrements each cycle.
  - When it reaches 0: if s<LOGN-1, then s++, k=0, go to RUN; else go to DONE.
- DONE
  - done=1 for exactly this cycle.
  - Next state is RUN if start is high, else IDLE.
- Address arithmetic, with half=1<<s, j=k&(half-1), g=k>>s:
  - addr_a = (g<<(s+1)) | j
  - addr_b = addr_a + half
  - tw_idx = j<<(LOGN-1-s)
  - All values are unsigned and truncated to the port widths. k is LOGN-1 bits wide and never wraps inside a stage.
- Write side: {rd_en, addr_a, addr_b} feeds a PIPE-deep shift register whose output is {wr_en, wr_addr_a, wr_addr_b}.
  - The register shifts every cycle in all states.
  - Reset and abort zero every valid bit.
- Outside RUN, addr_a, addr_b and tw_idx are held at 0.
- start while busy is ignored, with no queueing.
- abort in any state: next state is IDLE; s, k, drain counter and the write pipeline clear; done is not pulsed.
- Simultaneous start and abort: abort wins.
- Reset values: all outputs 0, state IDLE.

## Timing

- start sampled high at edge E: RUN from E+1, so rd_en is high in the cycle after E.
- Each stage takes N/2 RUN cycles plus PIPE DRAIN cycles.
- busy stays high for exactly LOGN*(N/2+PIPE) cycles. done pulses in the first cycle after busy falls.
- The last write of stage s lands on the final DRAIN cycle. The first read of stage s+1 is on the next cycle, so there is no read-after-write hazard and no bypass is needed.
- The twiddle ROM is addressed in the same cycle as the RAM read. Its latency must equal the RAM latency; the datapath owns any alignment beyond that.
- Reset asserted mid-transform forces the idle state immediately and asynchronously, with all outputs 0 and no pending writes.

## Test plan

- Reset values: with LOGN=3, PIPE=2, release reset -> all outputs 0 and IDLE; start pulse -> rd_en in cycle 1, busy high for 18 cycles, done high in cycle 19 only.
- Address sequence, LOGN=3, one (addr_a, addr_b, tw_idx) triple per RUN cycle:
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
- Write alignment: wr_en and wr_addr_a/b equal rd_en and addr_a/b delayed exactly PIPE cycles, checked for PIPE=1 and PIPE=4; no wr_en after done.
- Start during busy, plus back-to-back start: start pulsed mid-stage-1 -> ignored, sequence unchanged; start held high through DONE -> RUN again with no IDLE cycle.
- Abort: abort in stage 1, RUN at k=2 -> next cycle IDLE, busy=0, wr_en=0 immediately, no done pulse; a new start gives a full sequence from stage 0.
- Async reset mid-DRAIN: rst_n low between clock edges -> outputs 0 without waiting for a clock edge.
- End-to-end with LOGN=10: a RAM model plus a behavioural butterfly, fed a bit-reversed impulse at index 0 -> all 1024 bins equal 1+0j.
